// File: rtl/uart_reg_dump_pkg.sv
// rtl/uart_reg_dump_pkg.sv - shared types, ASCII constants and hex helper for uart_reg_dump
// Optional sequence prefix controlled by UART_REG_DUMP_SEQ_EN.
package uart_reg_dump_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    localparam logic [7:0] CHR_R     = 8'h72;
    localparam logic [7:0] CHR_EQ    = 8'h3D;
    localparam logic [7:0] CHR_0     = 8'h30;
    localparam logic [7:0] CHR_X     = 8'h78;
    localparam logic [7:0] CHR_CR    = 8'h0D;
    localparam logic [7:0] CHR_LF    = 8'h0A;
    localparam logic [7:0] CHR_COLON = 8'h3A;

`ifdef UART_REG_DUMP_SEQ_EN
    localparam int SEQ_PRE_LEN = 3;
`else
    localparam int SEQ_PRE_LEN = 0;
`endif

    // Uppercase hex: 'A' - 10 == 8'h37
    function automatic logic [7:0] hex2ascii(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

endpackage

// File: rtl/uart_line_fmt.sv
// rtl/uart_line_fmt.sv - combinational byte generator for one "r<i>=0x<hex>\r\n" line
// Adds "<seq>:" prefix when UART_REG_DUMP_SEQ_EN is defined.
module uart_line_fmt
    import uart_reg_dump_pkg::*;
#(
    parameter int REG_W = 16
) (
    input  logic [4:0]       byte_idx_i,
    input  logic [3:0]       reg_idx_i,
    input  logic [REG_W-1:0] snap_i,
`ifdef UART_REG_DUMP_SEQ_EN
    input  logic [7:0]       seq_i,
`endif
    output logic [7:0]       data_o
);

    localparam int HEX_DIGITS = REG_W / 4;

    logic [4:0] pos;
    logic [3:0] nib;

    always_comb begin
        data_o = 8'h00;
        nib    = 4'h0;
        pos    = byte_idx_i - 5'(SEQ_PRE_LEN);
        for (int k = 0; k < HEX_DIGITS; k++) begin
            if (pos == 5'(5 + k)) nib = snap_i[4*(HEX_DIGITS-1-k) +: 4];
        end
`ifdef UART_REG_DUMP_SEQ_EN
        if (byte_idx_i < 5'(SEQ_PRE_LEN)) begin
            case (byte_idx_i)
                5'd0:    data_o = hex2ascii(seq_i[7:4]);
                5'd1:    data_o = hex2ascii(seq_i[3:0]);
                default: data_o = CHR_COLON;
            endcase
        end else
`endif
        begin
            if (pos == 5'd0)                       data_o = CHR_R;
            else if (pos == 5'd1)                  data_o = hex2ascii(reg_idx_i);
            else if (pos == 5'd2)                  data_o = CHR_EQ;
            else if (pos == 5'd3)                  data_o = CHR_0;
            else if (pos == 5'd4)                  data_o = CHR_X;
            else if (pos < 5'(5 + HEX_DIGITS))     data_o = hex2ascii(nib);
            else if (pos == 5'(5 + HEX_DIGITS))    data_o = CHR_CR;
            else                                   data_o = CHR_LF;
        end
    end

endmodule

// File: rtl/uart_reg_dump.sv
// rtl/uart_reg_dump.sv - streams one ASCII line per changed register over a valid/ready byte port
// Optional sequence-number prefix controlled by UART_REG_DUMP_SEQ_EN.
module uart_reg_dump
    import uart_reg_dump_pkg::*;
#(
    parameter int NUM_REGS = 8,
    parameter int REG_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] regs [NUM_REGS],
    input  logic             force_dump,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic             busy,
    output logic             line_done
);

    localparam int         HEX_DIGITS = REG_W / 4;
    localparam int         LINE_LEN   = SEQ_PRE_LEN + 7 + HEX_DIGITS;
    localparam logic [4:0] LAST_BYTE  = 5'(LINE_LEN - 1);
    localparam logic [3:0] LAST_REG   = 4'(NUM_REGS - 1);

    state_e                state_q, state_d;
    logic [REG_W-1:0]      shadow_q [NUM_REGS];
    logic [REG_W-1:0]      shadow_d [NUM_REGS];
    logic [NUM_REGS-1:0]   pending_q, pending_d;
    logic [3:0]            rr_q, rr_d;
    logic [3:0]            sel_q, sel_d;
    logic [REG_W-1:0]      snap_q, snap_d;
    logic [4:0]            byte_q, byte_d;
    logic                  line_done_q, line_done_d;
`ifdef UART_REG_DUMP_SEQ_EN
    logic [7:0]            seq_q, seq_d;
`endif

    logic                  pick_ge, pick_any;
    logic [3:0]            pick_ge_idx, pick_any_idx, pick;
    logic [7:0]            fmt_byte;

    // Descending scan: the last hit is the lowest index; prefer hits at/after rr_q
    always_comb begin
        pick_ge      = 1'b0;
        pick_any     = 1'b0;
        pick_ge_idx  = 4'h0;
        pick_any_idx = 4'h0;
        for (int i = NUM_REGS - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                pick_any     = 1'b1;
                pick_any_idx = 4'(i);
                if (i >= int'(rr_q)) begin
                    pick_ge     = 1'b1;
                    pick_ge_idx = 4'(i);
                end
            end
        end
        pick = pick_ge ? pick_ge_idx : pick_any_idx;
    end

    always_comb begin
        state_d     = state_q;
        shadow_d    = shadow_q;
        rr_d        = rr_q;
        sel_d       = sel_q;
        snap_d      = snap_q;
        byte_d      = byte_q;
        line_done_d = 1'b0;
`ifdef UART_REG_DUMP_SEQ_EN
        seq_d       = line_done_q ? seq_q + 8'd1 : seq_q;
`endif
        pending_d = pending_q | {NUM_REGS{force_dump}};
        for (int i = 0; i < NUM_REGS; i++) begin
            if (regs[i] != shadow_q[i]) pending_d[i] = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    // Clearing after the set above lets the selection win over a same-cycle change
                    for (int i = 0; i < NUM_REGS; i++) begin
                        if (pick == 4'(i)) begin
                            snap_d       = regs[i];
                            shadow_d[i]  = regs[i];
                            pending_d[i] = 1'b0;
                        end
                    end
                    rr_d    = (pick == LAST_REG) ? 4'h0 : pick + 4'h1;
                    sel_d   = pick;
                    byte_d  = 5'd0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (tx_ready) begin
                    if (byte_q == LAST_BYTE) begin
                        byte_d      = 5'd0;
                        line_done_d = 1'b1;
                        state_d     = IDLE;
                    end else begin
                        byte_d = byte_q + 5'd1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            for (int i = 0; i < NUM_REGS; i++) shadow_q[i] <= '0;
            pending_q   <= '0;
            rr_q        <= 4'h0;
            sel_q       <= 4'h0;
            snap_q      <= '0;
            byte_q      <= 5'd0;
            line_done_q <= 1'b0;
`ifdef UART_REG_DUMP_SEQ_EN
            seq_q       <= 8'h00;
`endif
        end else begin
            state_q     <= state_d;
            shadow_q    <= shadow_d;
            pending_q   <= pending_d;
            rr_q        <= rr_d;
            sel_q       <= sel_d;
            snap_q      <= snap_d;
            byte_q      <= byte_d;
            line_done_q <= line_done_d;
`ifdef UART_REG_DUMP_SEQ_EN
            seq_q       <= seq_d;
`endif
        end
    end

    uart_line_fmt #(.REG_W(REG_W)) u_fmt (
        .byte_idx_i (byte_q),
        .reg_idx_i  (sel_q),
        .snap_i     (snap_q),
`ifdef UART_REG_DUMP_SEQ_EN
        .seq_i      (seq_q),
`endif
        .data_o     (fmt_byte)
    );

    assign tx_valid  = (state_q == SEND);
    assign busy      = (state_q == SEND);
    assign tx_data   = tx_valid ? fmt_byte : 8'h00;
    assign line_done = line_done_q;

endmodule

// File: tb/tb_uart_reg_dump.sv
// tb/tb_uart_reg_dump.sv - directed self-checking bench for uart_reg_dump
// Honours UART_REG_DUMP_SEQ_EN for the expected line prefix.
module tb_uart_reg_dump;

    localparam int NR = 8;
    localparam int RW = 16;
    localparam int HD = RW / 4;
`ifdef UART_REG_DUMP_SEQ_EN
    localparam int PRE = 3;
`else
    localparam int PRE = 0;
`endif
    localparam int LLEN = PRE + 7 + HD;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [RW-1:0] regs [NR];
    logic          force_dump = 1'b0;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready = 1'b1;
    logic          busy;
    logic          line_done;

    always #5 clk = ~clk;

    uart_reg_dump #(.NUM_REGS(NR), .REG_W(RW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .regs       (regs),
        .force_dump (force_dump),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .busy       (busy),
        .line_done  (line_done)
    );

    int         n_checks = 0;
    int         n_fail = 0;
    logic [7:0] exp_q [$];
    logic [7:0] cur_line [$];
    logic [7:0] last_line [$];
    logic [7:0] lit1 [$];
    int         seq_m = 0;
    int         ready_mode = 0;
    int         rcyc = 0;
    int         acc_cnt = 0;
    int         ld_cnt = 0;
    int         pos = 0;
    logic       ld_exp = 1'b0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;

    function automatic logic [7:0] hexc(input int d);
        return (d < 10) ? 8'(48 + d) : 8'(55 + d);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a line is fully determined by index, value and lines-since-reset
    task automatic push_line(input int idx, input int val);
`ifdef UART_REG_DUMP_SEQ_EN
        exp_q.push_back(hexc((seq_m >> 4) & 15));
        exp_q.push_back(hexc(seq_m & 15));
        exp_q.push_back(8'h3A);
`endif
        seq_m = (seq_m + 1) % 256;
        exp_q.push_back(8'h72);
        exp_q.push_back(hexc(idx));
        exp_q.push_back(8'h3D);
        exp_q.push_back(8'h30);
        exp_q.push_back(8'h78);
        for (int d = HD - 1; d >= 0; d--) exp_q.push_back(hexc((val >> (4 * d)) & 15));
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    always @(posedge clk) begin
        #1;
        if (ready_mode == 0) begin
            tx_ready = 1'b1;
        end else if (ready_mode == 1) begin
            rcyc++;
            tx_ready = (rcyc % 3 == 0);
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            pos = 0;
            ld_exp = 1'b0;
            prev_stall = 1'b0;
            cur_line.delete();
        end else begin
            logic ld_next;
            ld_next = 1'b0;
            check("line_done", line_done, ld_exp);
            if (line_done) ld_cnt++;
            check("busy_eq_valid", busy, tx_valid);
            if (pos != 0) check("valid_in_line", tx_valid, 1);
            if (ld_exp) check("idle_gap", tx_valid, 0);
            if (prev_stall) begin
                check("stall_valid", tx_valid, 1);
                check("stall_data", tx_data, prev_data);
            end
            if (tx_valid && tx_ready) begin
                acc_cnt++;
                cur_line.push_back(tx_data);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_byte: got %0h expected none at %0t", tx_data, $time);
                end else begin
                    check("tx_data", tx_data, exp_q.pop_front());
                end
                pos++;
                if (pos == LLEN) begin
                    pos = 0;
                    ld_next = 1'b1;
                    last_line = cur_line;
                    cur_line.delete();
                end
            end
            ld_exp = ld_next;
            prev_stall = tx_valid && !tx_ready;
            prev_data = tx_data;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        force_dump = 1'b0;
        for (int i = 0; i < NR; i++) regs[i] = '0;
        exp_q.delete();
        seq_m = 0;
        step(2);
        check("rst_valid", tx_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_line_done", line_done, 0);
        check("rst_data", tx_data, 8'h00);
        rst_n = 1'b1;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int c;
        c = 0;
        while ((exp_q.size() != 0 || tx_valid) && c < budget) begin
            step(1);
            c++;
        end
        check(name, (c < budget) ? 1 : 0, 1);
        step(5);
        check({name, "_idle"}, tx_valid, 0);
    endtask

    task automatic check_lit(input string name);
        check({name, "_len"}, last_line.size(), lit1.size());
        for (int i = 0; i < lit1.size(); i++) begin
            if (i < last_line.size()) check({name, "_byte"}, last_line[i], lit1[i]);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ld0, a0, c;
`ifdef UART_REG_DUMP_SEQ_EN
        lit1 = '{8'h30, 8'h30, 8'h3A, 8'h72, 8'h37, 8'h3D, 8'h30, 8'h78,
                 8'h31, 8'h32, 8'h41, 8'h42, 8'h0D, 8'h0A};
`else
        lit1 = '{8'h72, 8'h37, 8'h3D, 8'h30, 8'h78,
                 8'h31, 8'h32, 8'h41, 8'h42, 8'h0D, 8'h0A};
`endif
        do_reset();
        repeat (100) begin
            @(negedge clk);
            check("quiet_valid", tx_valid, 0);
            check("quiet_data", tx_data, 8'h00);
        end

        // Single change, with first-byte latency pinned
        step(1);
        regs[7] = 16'h12AB;
        push_line(7, 'h12AB);
        ld0 = ld_cnt;
        repeat (2) @(negedge clk);
        check("lat_detect", tx_valid, 0);
        @(negedge clk);
        check("lat_first", tx_valid, 1);
        wait_drain("t1_drain", 100);
        check("t1_ld_count", ld_cnt - ld0, 1);
        check_lit("t1");

        // Same line under 1-in-3 backpressure
        do_reset();
        ready_mode = 1;
        regs[7] = 16'h12AB;
        push_line(7, 'h12AB);
        wait_drain("t2_drain", 200);
        ready_mode = 0;
        check_lit("t2");

        // Two simultaneous changes, then round-robin continues from index 6
        do_reset();
        regs[2] = 16'h0001;
        regs[5] = 16'hFFFF;
        push_line(2, 'h0001);
        push_line(5, 'hFFFF);
        wait_drain("t3a_drain", 200);
        regs[1] = 16'h00C3;
        regs[7] = 16'h0777;
        push_line(7, 'h0777);
        push_line(1, 'h00C3);
        wait_drain("t3b_drain", 200);
        check("t3_last_idx", (last_line.size() > PRE + 1) ? last_line[PRE + 1] : 8'h00, 8'h31);

        // Change during a stalled line yields a second line
        do_reset();
        ready_mode = 2;
        tx_ready = 1'b0;
        regs[3] = 16'h0010;
        push_line(3, 'h0010);
        push_line(3, 'h0020);
        c = 0;
        while (!tx_valid && c < 20) begin
            step(1);
            c++;
        end
        check("t4_start", tx_valid, 1);
        tx_ready = 1'b1;
        step(4);
        tx_ready = 1'b0;
        step(1);
        regs[3] = 16'h0020;
        step(3);
        ready_mode = 0;
        tx_ready = 1'b1;
        wait_drain("t4_drain", 200);

        // Forced full dump
        do_reset();
        force_dump = 1'b1;
        step(1);
        force_dump = 1'b0;
        for (int i = 0; i < NR; i++) push_line(i, 0);
        ld0 = ld_cnt;
        wait_drain("t5_drain", 500);
        check("t5_ld_count", ld_cnt - ld0, NR);

        // Reset in the middle of a line aborts it for good
        do_reset();
        force_dump = 1'b1;
        step(1);
        force_dump = 1'b0;
        for (int i = 0; i < NR; i++) push_line(i, 0);
        a0 = acc_cnt;
        c = 0;
        while (acc_cnt - a0 < 6 && c < 50) begin
            step(1);
            c++;
        end
        check("t6_reach", acc_cnt - a0, 6);
        rst_n = 1'b0;
        exp_q.delete();
        seq_m = 0;
        step(1);
        check("t6_valid", tx_valid, 0);
        check("t6_busy", busy, 0);
        rst_n = 1'b1;
        a0 = acc_cnt;
        step(40);
        check("t6_quiet", acc_cnt - a0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
